// File: rtl/func_sweep_ctrl.sv
// func_sweep_ctrl: truth-table sweep controller for a 4-input, 1-output
// combinational function unit. Each of the 16 input vectors is driven in
// ascending order and the unit's output is sampled after SETTLE settle cycles.
// The measured table is compared against a latched expected mask, and the
// mismatch count and the first failing index are reported.
module func_sweep_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] expected,
    input  logic        g_in,
    output logic [3:0]  abcd,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_out,
    output logic [4:0]  err_count,
    output logic        err_any,
    output logic [3:0]  first_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Reload value for the settle counter, and the state a new vector starts
    // in: with no settle time the vector is sampled in its first cycle.
    localparam logic [3:0] SETTLE_LD = 4'(SETTLE);
    localparam state_t     VEC_ENTRY = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  abcd_q, abcd_d;
    logic [15:0] exp_q, exp_d;
    logic [15:0] table_q, table_d;
    logic [4:0]  err_count_q, err_count_d;
    logic        err_any_q, err_any_d;
    logic [3:0]  first_err_q, first_err_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        mismatch;

    // Next-state and next-output logic for the sweep sequencer.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        abcd_d      = abcd_q;
        exp_d       = exp_q;
        table_d     = table_q;
        err_count_d = err_count_q;
        err_any_d   = err_any_q;
        first_err_d = first_err_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        mismatch    = (g_in != exp_q[idx_q]);

        case (state_q)
            S_IDLE, S_DONE: begin
                // Abort wins over a simultaneous start; otherwise start is
                // accepted identically from IDLE and DONE.
                if (start && !abort) begin
                    exp_d       = expected;
                    table_d     = 16'd0;
                    err_count_d = 5'd0;
                    err_any_d   = 1'b0;
                    first_err_d = 4'd0;
                    idx_d       = 4'd0;
                    cnt_d       = SETTLE_LD;
                    abcd_d      = 4'd0;
                    busy_d      = 1'b1;
                    state_d     = VEC_ENTRY;
                end else begin
                    abcd_d  = 4'd0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end

            S_SETTLE: begin
                if (abort) begin
                    state_d     = S_IDLE;
                    idx_d       = 4'd0;
                    cnt_d       = 4'd0;
                    abcd_d      = 4'd0;
                    table_d     = 16'd0;
                    err_count_d = 5'd0;
                    err_any_d   = 1'b0;
                    first_err_d = 4'd0;
                    busy_d      = 1'b0;
                end else begin
                    // Counter holds the remaining settle cycles including
                    // this one, so the state lasts exactly SETTLE cycles.
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d = S_SAMPLE;
                    end
                end
            end

            S_SAMPLE: begin
                if (abort) begin
                    state_d     = S_IDLE;
                    idx_d       = 4'd0;
                    cnt_d       = 4'd0;
                    abcd_d      = 4'd0;
                    table_d     = 16'd0;
                    err_count_d = 5'd0;
                    err_any_d   = 1'b0;
                    first_err_d = 4'd0;
                    busy_d      = 1'b0;
                end else begin
                    table_d[idx_q] = g_in;
                    if (mismatch) begin
                        err_count_d = err_count_q + 5'd1;
                        if (!err_any_q) begin
                            err_any_d   = 1'b1;
                            first_err_d = idx_q;
                        end
                    end
                    if (idx_q == 4'd15) begin
                        state_d = S_DONE;
                        abcd_d  = 4'd0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        abcd_d  = idx_q + 4'd1;
                        cnt_d   = SETTLE_LD;
                        state_d = VEC_ENTRY;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                abcd_d  = 4'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= 4'd0;
            cnt_q       <= 4'd0;
            abcd_q      <= 4'd0;
            exp_q       <= 16'd0;
            table_q     <= 16'd0;
            err_count_q <= 5'd0;
            err_any_q   <= 1'b0;
            first_err_q <= 4'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            abcd_q      <= abcd_d;
            exp_q       <= exp_d;
            table_q     <= table_d;
            err_count_q <= err_count_d;
            err_any_q   <= err_any_d;
            first_err_q <= first_err_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign abcd      = abcd_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign table_out = table_q;
    assign err_count = err_count_q;
    assign err_any   = err_any_q;
    assign first_err = first_err_q;

endmodule
